// File: rtl/single_port_ram_arbiter_pkg.sv
// Shared constants for single_port_ram_arbiter: ceiling-log2 helper and
// response-type encodings used when SINGLE_PORT_RAM_ARBITER_WRITE_RESPONSE_EN is defined.
package single_port_ram_arbiter_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned remaining;
    result    = 0;
    remaining = (value > 0) ? value - 1 : 0;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  typedef enum logic {
    RESPONSE_READ  = 1'b0,
    RESPONSE_WRITE = 1'b1
  } response_type_t;

endpackage

// File: rtl/single_port_ram_arbiter_round_robin_arbiter.sv
// Round-robin arbiter: grants the first active request at or above the
// pointer (with wrap); the pointer moves past the winner when advance is high.
module round_robin_arbiter
  import single_port_ram_arbiter_pkg::*;
#(
  parameter int unsigned REQUESTERS  = 2,
  parameter int unsigned INDEX_WIDTH = clog2(REQUESTERS)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [REQUESTERS-1:0]  requests,
  input  logic                   advance,
  output logic [REQUESTERS-1:0]  grant,
  output logic [INDEX_WIDTH-1:0] grant_index
);

  logic [INDEX_WIDTH-1:0]  pointer;
  logic [INDEX_WIDTH-1:0]  next_pointer;
  logic [2*REQUESTERS-1:0] doubled;
  logic [REQUESTERS-1:0]   rotated;
  logic [INDEX_WIDTH:0]    sum;
  logic [INDEX_WIDTH:0]    incremented;
  logic                    found;

  // Rotate so that bit 0 is the pointer position; a fixed-priority scan then
  // gives the round-robin order without variable-index selects.
  always_comb begin
    doubled     = {requests, requests} >> pointer;
    rotated     = doubled[REQUESTERS-1:0];
    grant       = '0;
    grant_index = '0;
    found       = 1'b0;
    sum         = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      if (!found && rotated[i]) begin
        found = 1'b1;
        sum   = {1'b0, pointer} + (INDEX_WIDTH+1)'(i);
        if (sum >= (INDEX_WIDTH+1)'(REQUESTERS)) begin
          sum = sum - (INDEX_WIDTH+1)'(REQUESTERS);
        end
        grant_index = sum[INDEX_WIDTH-1:0];
        grant       = REQUESTERS'(1) << sum[INDEX_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    incremented = {1'b0, grant_index} + (INDEX_WIDTH+1)'(1);
    if (incremented >= (INDEX_WIDTH+1)'(REQUESTERS)) begin
      next_pointer = '0;
    end else begin
      next_pointer = incremented[INDEX_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      pointer <= '0;
    end else if (advance) begin
      pointer <= next_pointer;
    end
  end

endmodule

// File: rtl/single_port_ram_arbiter.sv
// Shares one single_port_ram between N valid/ready requesters with round-robin
// grant and routed read responses. Optional: SINGLE_PORT_RAM_ARBITER_WRITE_RESPONSE_EN.
module single_port_ram_arbiter
  import single_port_ram_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned REQUESTERS    = 2,
  parameter int unsigned ADDRESS_WIDTH = clog2(DEPTH),
  parameter int unsigned INDEX_WIDTH   = clog2(REQUESTERS)
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic [REQUESTERS-1:0]             request_valid,
  output logic [REQUESTERS-1:0]             request_ready,
  input  logic [REQUESTERS-1:0]             request_write,
  input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] request_address,
  input  logic [REQUESTERS*WIDTH-1:0]       request_write_data,
  output logic [REQUESTERS-1:0]             response_valid,
  output logic [WIDTH-1:0]                  response_data,
  output logic                              ram_access_enable,
  output logic                              ram_write,
  output logic [ADDRESS_WIDTH-1:0]          ram_address,
  output logic [WIDTH-1:0]                  ram_write_data,
  input  logic [WIDTH-1:0]                  ram_read_data
);

  logic [REQUESTERS-1:0]  gated_valid;
  logic [REQUESTERS-1:0]  grant;
  logic [INDEX_WIDTH-1:0] grant_index;
  logic                   issue;
  logic                   respond_now;
  logic [REQUESTERS-1:0]  pending_valid;
  logic                   pending_is_write;

  assign gated_valid = request_valid & {REQUESTERS{resetn}};

  round_robin_arbiter #(
    .REQUESTERS (REQUESTERS),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_round_robin_arbiter (
    .clock      (clock),
    .resetn     (resetn),
    .requests   (gated_valid),
    .advance    (issue),
    .grant      (grant),
    .grant_index(grant_index)
  );

  assign issue             = |grant;
  assign request_ready     = grant;
  assign ram_access_enable = issue;

  always_comb begin
    ram_write      = request_write[0];
    ram_address    = request_address[ADDRESS_WIDTH-1:0];
    ram_write_data = request_write_data[WIDTH-1:0];
    for (int unsigned i = 1; i < REQUESTERS; i++) begin
      if (grant[i]) begin
        ram_write      = request_write[i];
        ram_address    = request_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        ram_write_data = request_write_data[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef SINGLE_PORT_RAM_ARBITER_WRITE_RESPONSE_EN
  response_type_t issue_type;
  assign issue_type  = ram_write ? RESPONSE_WRITE : RESPONSE_READ;
  assign respond_now = issue;
`else
  assign respond_now = issue && !ram_write;
`endif

  generate
    if (READ_LATENCY == 0) begin : g_latency0
      assign pending_valid = respond_now ? grant : '0;
`ifdef SINGLE_PORT_RAM_ARBITER_WRITE_RESPONSE_EN
      assign pending_is_write = (issue_type == RESPONSE_WRITE);
`else
      assign pending_is_write = 1'b0;
`endif
    end else begin : g_latency1
      logic                   response_valid_q;
      logic [INDEX_WIDTH-1:0] response_index_q;

      always_ff @(posedge clock) begin
        if (!resetn) begin
          response_valid_q <= 1'b0;
        end else begin
          response_valid_q <= respond_now;
        end
        response_index_q <= grant_index;
      end

`ifdef SINGLE_PORT_RAM_ARBITER_WRITE_RESPONSE_EN
      response_type_t response_type_q;
      always_ff @(posedge clock) begin
        response_type_q <= issue_type;
      end
      assign pending_is_write = (response_type_q == RESPONSE_WRITE);
`else
      assign pending_is_write = 1'b0;
`endif
      assign pending_valid = response_valid_q ? (REQUESTERS'(1) << response_index_q) : '0;
    end
  endgenerate

  // Masking with resetn drops a response that was in flight when reset hit.
  assign response_valid = resetn ? pending_valid : '0;
  assign response_data  = pending_is_write ? '0 : ram_read_data;

endmodule

// File: tb/tb_single_port_ram_arbiter.sv
// Directed bench for single_port_ram_arbiter: an N=2/latency-1 instance and an
// N=4/latency-0 instance, each in front of a behavioural RAM model.
module tb_single_port_ram_arbiter;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [1:0]  a_valid, a_ready, a_write, a_resp;
  logic [7:0]  a_addr;
  logic [15:0] a_wdata;
  logic [7:0]  a_data, a_ram_wd, a_ram_rd;
  logic        a_en, a_we;
  logic [3:0]  a_ram_addr;
  logic [7:0]  mem_a [16];

  logic [3:0]  b_valid, b_ready, b_write, b_resp;
  logic [15:0] b_addr;
  logic [31:0] b_wdata;
  logic [7:0]  b_data, b_ram_wd, b_ram_rd;
  logic        b_en, b_we;
  logic [3:0]  b_ram_addr;
  logic [7:0]  mem_b [16];

  single_port_ram_arbiter #(
    .WIDTH(8), .DEPTH(16), .READ_LATENCY(1), .REQUESTERS(2)
  ) dut_a (
    .clock(clock), .resetn(resetn),
    .request_valid(a_valid), .request_ready(a_ready), .request_write(a_write),
    .request_address(a_addr), .request_write_data(a_wdata),
    .response_valid(a_resp), .response_data(a_data),
    .ram_access_enable(a_en), .ram_write(a_we), .ram_address(a_ram_addr),
    .ram_write_data(a_ram_wd), .ram_read_data(a_ram_rd)
  );

  single_port_ram_arbiter #(
    .WIDTH(8), .DEPTH(16), .READ_LATENCY(0), .REQUESTERS(4)
  ) dut_b (
    .clock(clock), .resetn(resetn),
    .request_valid(b_valid), .request_ready(b_ready), .request_write(b_write),
    .request_address(b_addr), .request_write_data(b_wdata),
    .response_valid(b_resp), .response_data(b_data),
    .ram_access_enable(b_en), .ram_write(b_we), .ram_address(b_ram_addr),
    .ram_write_data(b_ram_wd), .ram_read_data(b_ram_rd)
  );

  // Registered-read RAM model for dut_a; contents cleared while in reset.
  always @(posedge clock) begin
    if (!resetn) begin
      for (int k = 0; k < 16; k++) mem_a[k] <= 8'h00;
    end else if (a_en) begin
      if (a_we) mem_a[a_ram_addr] <= a_ram_wd;
      else      a_ram_rd <= mem_a[a_ram_addr];
    end
  end

  // Combinational-read RAM model for dut_b; preloaded while in reset.
  always @(posedge clock) begin
    if (!resetn) begin
      for (int k = 0; k < 16; k++) mem_b[k] <= (k == 5) ? 8'h3C : 8'(8'h40 + k);
    end else if (b_en && b_we) begin
      mem_b[b_ram_addr] <= b_ram_wd;
    end
  end
  assign b_ram_rd = mem_b[b_ram_addr];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] b_expected(input int unsigned address);
    return (address == 5) ? 8'h3C : 8'(8'h40 + address);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int unsigned g;
    resetn  = 1'b0;
    a_valid = 2'b11; a_write = '0; a_addr = '0; a_wdata = '0;
    b_valid = 4'hF;  b_write = '0; b_addr = '0; b_wdata = '0;
    next_cycle();
    @(negedge clock);
    check("reset_a_ready", 32'(a_ready), 32'h0);
    check("reset_a_en",    32'(a_en),    32'h0);
    check("reset_a_resp",  32'(a_resp),  32'h0);
    check("reset_b_ready", 32'(b_ready), 32'h0);
    check("reset_b_en",    32'(b_en),    32'h0);
    check("reset_b_resp",  32'(b_resp),  32'h0);
    next_cycle();
    resetn = 1'b1; a_valid = '0; b_valid = '0;

    // Requester 0 writes 0xA5 to address 3
    a_valid = 2'b01; a_write = 2'b01; a_addr = {4'd0, 4'd3}; a_wdata = {8'h00, 8'hA5};
    @(negedge clock);
    check("wr_ready",    32'(a_ready),    32'h1);
    check("wr_en",       32'(a_en),       32'h1);
    check("wr_we",       32'(a_we),       32'h1);
    check("wr_addr",     32'(a_ram_addr), 32'h3);
    check("wr_data",     32'(a_ram_wd),   32'hA5);
    check("wr_no_resp",  32'(a_resp),     32'h0);
    next_cycle();

    // Requester 0 reads address 3
    a_write = 2'b00;
    @(negedge clock);
    check("rd_ready", 32'(a_ready), 32'h1);
    check("rd_we",    32'(a_we),    32'h0);
`ifdef SINGLE_PORT_RAM_ARBITER_WRITE_RESPONSE_EN
    check("wr_resp_valid", 32'(a_resp), 32'h1);
    check("wr_resp_data",  32'(a_data), 32'h0);
`else
    check("wr_resp_none",  32'(a_resp), 32'h0);
`endif
    next_cycle();
    a_valid = 2'b00;
    @(negedge clock);
    check("idle_en",      32'(a_en),   32'h0);
    check("rd_resp",      32'(a_resp), 32'h1);
    check("rd_resp_data", 32'(a_data), 32'hA5);
    next_cycle();

    // Preload address 1 (req0) and address 2 (req1); pointer returns to 0
    a_valid = 2'b01; a_write = 2'b01; a_addr = {4'd0, 4'd1}; a_wdata = {8'h00, 8'h11};
    @(negedge clock);
    check("pre0_ready", 32'(a_ready), 32'h1);
    check("pre0_resp",  32'(a_resp),  32'h0);
    next_cycle();
    a_valid = 2'b10; a_write = 2'b10; a_addr = {4'd2, 4'd1}; a_wdata = {8'h22, 8'h11};
    @(negedge clock);
    check("pre1_ready", 32'(a_ready),    32'h2);
    check("pre1_addr",  32'(a_ram_addr), 32'h2);
    check("pre1_data",  32'(a_ram_wd),   32'h22);
    next_cycle();

    // Contention: both read for four cycles, grants 0,1,0,1
    a_valid = 2'b11; a_write = 2'b00;
    for (int c = 0; c < 4; c++) begin
      g = c % 2;
      @(negedge clock);
      check("cont_ready", 32'(a_ready),    32'(2'b01 << g));
      check("cont_addr",  32'(a_ram_addr), (g == 1) ? 32'h2 : 32'h1);
      if (c == 0) begin
`ifdef SINGLE_PORT_RAM_ARBITER_WRITE_RESPONSE_EN
        check("cont_wresp", 32'(a_resp), 32'h2);
        check("cont_wdata", 32'(a_data), 32'h0);
`else
        check("cont_first_resp", 32'(a_resp), 32'h0);
`endif
      end else begin
        check("cont_resp",      32'(a_resp), 32'(2'b01 << (1 - g)));
        check("cont_resp_data", 32'(a_data), (g == 1) ? 32'h11 : 32'h22);
      end
      next_cycle();
    end
    a_valid = 2'b00;
    @(negedge clock);
    check("cont_last_resp", 32'(a_resp), 32'h2);
    check("cont_last_data", 32'(a_data), 32'h22);
    next_cycle();

    // Reset while a read is in flight; pointer had moved to 1
    a_valid = 2'b01; a_addr = {4'd2, 4'd1};
    @(negedge clock);
    check("mid_issue_ready", 32'(a_ready), 32'h1);
    next_cycle();
    resetn = 1'b0; a_valid = 2'b11;
    @(negedge clock);
    check("mid_reset_resp",  32'(a_resp),  32'h0);
    check("mid_reset_ready", 32'(a_ready), 32'h0);
    next_cycle();
    resetn = 1'b1;
    @(negedge clock);
    check("post_reset_resp",  32'(a_resp),  32'h0);
    check("post_reset_grant", 32'(a_ready), 32'h1);
    next_cycle();
    a_valid = 2'b00;

    // Fairness on N=4, latency 0: requester i reads address i+2
    b_valid = 4'hF; b_write = 4'h0; b_addr = {4'd5, 4'd4, 4'd3, 4'd2};
    for (int c = 0; c < 8; c++) begin
      g = c % 4;
      @(negedge clock);
      check("fair_ready", 32'(b_ready), 32'(4'b0001 << g));
      check("fair_resp",  32'(b_resp),  32'(4'b0001 << g));
      check("fair_data",  32'(b_data),  32'(b_expected(g + 2)));
      next_cycle();
    end

    // Latency 0: read of address 5 holding 0x3C returns in the issue cycle
    b_valid = 4'b1000;
    @(negedge clock);
    check("lat0_ready", 32'(b_ready), 32'h8);
    check("lat0_resp",  32'(b_resp),  32'h8);
    check("lat0_data",  32'(b_data),  32'h3C);
    next_cycle();

    // Write 0x99 to address 0, then read it back the next cycle
    b_valid = 4'b0001; b_write = 4'b0001; b_addr = {4'd5, 4'd4, 4'd3, 4'd0}; b_wdata = 32'h0000_0099;
    @(negedge clock);
    check("b_wr_ready", 32'(b_ready), 32'h1);
    check("b_wr_we",    32'(b_we),    32'h1);
`ifdef SINGLE_PORT_RAM_ARBITER_WRITE_RESPONSE_EN
    check("b_wr_resp",      32'(b_resp), 32'h1);
    check("b_wr_resp_data", 32'(b_data), 32'h0);
`else
    check("b_wr_no_resp", 32'(b_resp), 32'h0);
`endif
    next_cycle();
    b_write = 4'b0000;
    @(negedge clock);
    check("b_rd_ready", 32'(b_ready), 32'h1);
    check("b_rd_resp",  32'(b_resp),  32'h1);
    check("b_rd_data",  32'(b_data),  32'h99);
    next_cycle();
    b_valid = 4'b0000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
